// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem addressing, IF/ID register, return-address stack and halt.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4,
    parameter logic [15:0] NO_OP     = 16'hF000,
    parameter logic [15:0] HALT_OP   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        call,
    input  logic [11:0] call_target,
    input  logic [15:0] dec_pc,
    input  logic        ret,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction_out,
    output logic [15:0] PC_out,
    output logic        halted,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        ras_err
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {RUN, BUBBLE, HALT} state_t;

    state_t            state;
    logic [15:0]       pc;
    logic [SP_W-1:0]   sp;
    logic [15:0]       ras_mem [RAS_DEPTH];

    logic              ras_empty;
    logic              ras_full;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [SP_W-1:0]   sp_dec;
    logic              active;
    logic              redirect;
    logic              hold;
    logic              do_push;

    assign imem_addr = pc;
    assign ras_empty = (sp == '0);
    assign ras_full  = (sp == SP_W'(RAS_DEPTH));
    assign sp_dec    = sp - 1'b1;
    assign push_idx  = sp[IDX_W-1:0];
    assign pop_idx   = sp_dec[IDX_W-1:0];
    assign active    = (state != HALT);
    assign redirect  = ret || call || branch_taken;
    assign hold      = (state == RUN) && stall;
    assign do_push   = active && !ret && call && !ras_full;

    // RAS storage carries no reset; only sp defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push)
            ras_mem[push_idx] <= dec_pc + 16'd1;
    end

    // BUBBLE is the cycle the NO_OP is visible; its edge already fetches from the new pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            pc              <= RESET_PC;
            sp              <= '0;
            instruction_out <= NO_OP;
            PC_out          <= 16'h0000;
            halted          <= 1'b0;
            ras_err         <= 1'b0;
        end else begin
            case (state)
                RUN, BUBBLE: begin
                    if (ret) begin
                        instruction_out <= NO_OP;
                        state           <= BUBBLE;
                        if (ras_empty) begin
                            pc      <= RESET_PC;
                            ras_err <= 1'b1;
                        end else begin
                            pc <= ras_mem[pop_idx];
                            sp <= sp_dec;
                        end
                    end else if (call) begin
                        pc              <= {dec_pc[15:12], call_target};
                        instruction_out <= NO_OP;
                        state           <= BUBBLE;
                        if (ras_full)
                            ras_err <= 1'b1;
                        else
                            sp <= sp + 1'b1;
                    end else if (branch_taken) begin
                        pc              <= branch_target;
                        instruction_out <= NO_OP;
                        state           <= BUBBLE;
                    end else if (!hold) begin
                        instruction_out <= imem_data;
                        PC_out          <= pc + 16'd1;
                        if (imem_data == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc    <= pc + 16'd1;
                            state <= RUN;
                        end
                    end
                end
                HALT: begin
                    instruction_out <= NO_OP;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_evt;
    logic bubble_evt;

    assign fetch_evt  = active && !redirect && !hold;
    assign bubble_evt = active && (redirect || hold);

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (fetch_evt && (fetch_cnt != 32'hFFFF_FFFF))
                fetch_cnt <= fetch_cnt + 32'd1;
            if (bubble_evt && (bubble_cnt != 32'hFFFF_FFFF))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with an address-tagged instruction memory model.
module tb_if_fetch_unit;

    localparam logic [15:0] NO_OP = 16'hF000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        call;
    logic [11:0] call_target;
    logic [15:0] dec_pc;
    logic        ret;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] instruction_out;
    logic [15:0] PC_out;
    logic        halted;
    logic        ras_err;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    logic        haltEnable;
    int          assertCount;
    int          failCount;

    if_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .call           (call),
        .call_target    (call_target),
        .dec_pc         (dec_pc),
        .ret            (ret),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instruction_out(instruction_out),
        .PC_out         (PC_out),
        .halted         (halted),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt      (fetch_cnt),
        .bubble_cnt     (bubble_cnt),
`endif
        .ras_err        (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] tagWord(input logic [15:0] addr);
        return addr ^ 16'hA500;
    endfunction

    // Instruction memory: every word is derived from its address, with an optional HALT at 7.
    always_comb begin
        imem_data = tagWord(imem_addr);
        if (haltEnable && (imem_addr == 16'h0007))
            imem_data = 16'hFFFF;
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stallIn, input logic branchIn, input logic [15:0] branchTgt,
                                 input logic callIn, input logic [11:0] callTgt, input logic [15:0] decPc,
                                 input logic retIn);
        stall         = stallIn;
        branch_taken  = branchIn;
        branch_target = branchTgt;
        call          = callIn;
        call_target   = callTgt;
        dec_pc        = decPc;
        ret           = retIn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b0);
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        haltEnable    = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0;
        call          = 1'b0;
        call_target   = 12'h0;
        dec_pc        = 16'h0;
        ret           = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_instr", instruction_out, NO_OP);
        checkOutput("reset_pcout", PC_out, 16'h0000);
        checkOutput("reset_halted", {15'b0, halted}, 16'h0);
        checkOutput("reset_raserr", {15'b0, ras_err}, 16'h0);
        checkOutput("reset_addr", imem_addr, 16'h0000);
        #4 rst_n = 1'b1;

        // Sequential fetch from address 0.
        for (int a = 0; a < 5; a++) begin
            idle();
            checkOutput("seq_instr", instruction_out, tagWord(16'(a)));
            checkOutput("seq_pcout", PC_out, 16'(a + 1));
        end
        checkOutput("seq_addr5", imem_addr, 16'h0005);

        // Stall three cycles at pc=5.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b0);
            checkOutput("stall_instr", instruction_out, tagWord(16'h0004));
            checkOutput("stall_pcout", PC_out, 16'h0005);
        end
        idle();
        checkOutput("post_stall_instr", instruction_out, tagWord(16'h0005));
        checkOutput("post_stall_pcout", PC_out, 16'h0006);

        // Taken branch to 0x0040.
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0, 12'h0, 16'h0, 1'b0);
        checkOutput("branch_bubble", instruction_out, NO_OP);
        checkOutput("branch_addr", imem_addr, 16'h0040);
        idle();
        checkOutput("branch_instr", instruction_out, tagWord(16'h0040));
        checkOutput("branch_pcout", PC_out, 16'h0041);

        // Call at dec_pc 0x0010, target 0x123, then return.
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 12'h123, 16'h0010, 1'b0);
        checkOutput("call_bubble", instruction_out, NO_OP);
        checkOutput("call_addr", imem_addr, 16'h0123);
        idle();
        checkOutput("call_instr", instruction_out, tagWord(16'h0123));
        checkOutput("call_pcout", PC_out, 16'h0124);
        idle();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b1);
        checkOutput("ret_bubble", instruction_out, NO_OP);
        checkOutput("ret_addr", imem_addr, 16'h0011);
        idle();
        checkOutput("ret_instr", instruction_out, tagWord(16'h0011));
        checkOutput("ret_pcout", PC_out, 16'h0012);
        checkOutput("ret_noerr", {15'b0, ras_err}, 16'h0);

        // Five nested calls overflow the 4-deep RAS.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 12'(12'h200 + i * 16), 16'(16'h0100 + i), 1'b0);
            checkOutput("nest_call_addr", imem_addr, 16'(16'h0200 + i * 16));
            idle();
            if (i == 3)
                checkOutput("nest_full_noerr", {15'b0, ras_err}, 16'h0);
        end
        checkOutput("nest_overflow_err", {15'b0, ras_err}, 16'h1);

        // Five returns: four popped addresses, then underflow to RESET_PC.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b1);
            checkOutput("nest_ret_addr", imem_addr, (i < 4) ? 16'(16'h0104 - i) : 16'h0000);
            checkOutput("nest_ret_bubble", instruction_out, NO_OP);
            idle();
        end
        checkOutput("underflow_instr", instruction_out, tagWord(16'h0000));

        // PC wraps FFFF -> 0000.
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0, 12'h0, 16'h0, 1'b0);
        idle();
        checkOutput("wrap_instr0", instruction_out, tagWord(16'hFFFE));
        idle();
        checkOutput("wrap_instr1", instruction_out, tagWord(16'hFFFF));
        checkOutput("wrap_pcout", PC_out, 16'h0000);
        checkOutput("wrap_addr", imem_addr, 16'h0000);

        // A redirect in the same cycle as a HALT fetch wins.
        haltEnable = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0006, 1'b0, 12'h0, 16'h0, 1'b0);
        idle();
        checkOutput("pre_halt_instr", instruction_out, tagWord(16'h0006));
        checkOutput("pre_halt_addr", imem_addr, 16'h0007);
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0, 12'h0, 16'h0, 1'b0);
        checkOutput("redir_over_halt_instr", instruction_out, NO_OP);
        checkOutput("redir_over_halt_flag", {15'b0, halted}, 16'h0);
        idle();
        checkOutput("redir_over_halt_next", instruction_out, tagWord(16'h0030));

        // HALT_OP passes once, then NO_OP with call/ret/branch ignored.
        applyStimulus(1'b0, 1'b1, 16'h0006, 1'b0, 12'h0, 16'h0, 1'b0);
        idle();
        idle();
        checkOutput("halt_instr", instruction_out, 16'hFFFF);
        checkOutput("halt_pcout", PC_out, 16'h0008);
        checkOutput("halt_flag", {15'b0, halted}, 16'h1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 12'h0, 16'h0, 1'b1);
        checkOutput("halt_ret_ignored", instruction_out, NO_OP);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 12'h055, 16'h0000, 1'b0);
        checkOutput("halt_call_ignored", instruction_out, NO_OP);
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0, 12'h0, 16'h0, 1'b0);
        idle();
        checkOutput("halt_branch_ignored", instruction_out, NO_OP);
        checkOutput("halt_pcout_held", PC_out, 16'h0008);
        checkOutput("halt_flag_held", {15'b0, halted}, 16'h1);
        checkOutput("halt_raserr_sticky", {15'b0, ras_err}, 16'h1);

        // Asynchronous reset mid-operation.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_instr", instruction_out, NO_OP);
        checkOutput("midrst_halted", {15'b0, halted}, 16'h0);
        checkOutput("midrst_raserr", {15'b0, ras_err}, 16'h0);
        checkOutput("midrst_addr", imem_addr, 16'h0000);
        #1 rst_n = 1'b1;
        idle();
        checkOutput("after_rst_instr", instruction_out, tagWord(16'h0000));
        checkOutput("after_rst_pcout", PC_out, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
